inst_fetcher: RTL and testbench



---
 rtl/inst_fetcher_pkg.sv | 11 +
 rtl/inst_fetcher.sv | 149 ++++++++++++++
 tb/tb_inst_fetcher.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetcher_pkg.sv
// Shared definitions for the instruction fetcher: FSM state encodings.
package inst_fetcher_pkg;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_HOLD  = 2'd2,
    IF_DROP  = 2'd3
  } if_state_e;

endpackage

// File: rtl/inst_fetcher.sv
// Fetch stage ahead of the decoder: owns the fetch PC, issues one icache
// request at a time, presents the returned instruction until it is issued.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_valid,
  input  logic [31:0] icache_inst,
  output logic        start_decode,
  output logic [31:0] inst,
  output logic [31:0] inst_addr,
  input  logic        issue_signal,
  input  logic        jalr_stall,
  input  logic [31:0] next_pc,
  input  logic        wrong_predicted,
  input  logic [31:0] correct_pc
);

  if_state_e   state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] stale_addr_r, stale_addr_s;
  logic [31:0] inst_r, inst_s;
  logic [31:0] inst_addr_r, inst_addr_s;
  logic        start_decode_r, start_decode_s;
  logic        icache_req_r, icache_req_s;
  logic [31:0] icache_addr_r, icache_addr_s;

  // A stall simply keeps HOLD re-presenting the instruction; no extra action.
  logic unused_s;
  assign unused_s = jalr_stall;

  // Next-state and next-output computation.
  always_comb begin
    state_s        = state_r;
    pc_s           = pc_r;
    stale_addr_s   = stale_addr_r;
    inst_s         = inst_r;
    inst_addr_s    = inst_addr_r;
    start_decode_s = start_decode_r;
    icache_req_s   = icache_req_r;
    icache_addr_s  = icache_addr_r;
    case (state_r)
      IF_IDLE: begin
        state_s        = IF_FETCH;
        start_decode_s = 1'b0;
        icache_req_s   = 1'b1;
        icache_addr_s  = pc_r;
      end
      IF_FETCH: begin
        if (!icache_req_r) begin
          // One-cycle gap after a flush that collided with a response.
          icache_req_s = 1'b1;
          if (wrong_predicted) begin
            pc_s          = correct_pc;
            icache_addr_s = correct_pc;
          end else begin
            icache_addr_s = pc_r;
          end
        end else if (icache_valid && wrong_predicted) begin
          pc_s          = correct_pc;
          icache_req_s  = 1'b0;
          icache_addr_s = correct_pc;
        end else if (icache_valid) begin
          state_s        = IF_HOLD;
          inst_s         = icache_inst;
          inst_addr_s    = pc_r;
          start_decode_s = 1'b1;
          icache_req_s   = 1'b0;
        end else if (wrong_predicted) begin
          state_s      = IF_DROP;
          stale_addr_s = pc_r;
          pc_s         = correct_pc;
        end else begin
          state_s = IF_FETCH;
        end
      end
      IF_HOLD: begin
        if (wrong_predicted) begin
          state_s        = IF_FETCH;
          pc_s           = correct_pc;
          start_decode_s = 1'b0;
          icache_req_s   = 1'b1;
          icache_addr_s  = correct_pc;
        end else if (issue_signal) begin
          state_s        = IF_FETCH;
          pc_s           = next_pc;
          start_decode_s = 1'b0;
          icache_req_s   = 1'b1;
          icache_addr_s  = next_pc;
        end else begin
          state_s = IF_HOLD;
        end
      end
      IF_DROP: begin
        if (icache_valid) begin
          state_s       = IF_FETCH;
          pc_s          = wrong_predicted ? correct_pc : pc_r;
          icache_req_s  = 1'b1;
          icache_addr_s = wrong_predicted ? correct_pc : pc_r;
        end else if (wrong_predicted) begin
          pc_s = correct_pc;
        end else begin
          state_s = IF_DROP;
        end
      end
      default: begin
        state_s        = IF_IDLE;
        start_decode_s = 1'b0;
        icache_req_s   = 1'b0;
      end
    endcase
  end

  // State and output registers; frozen while rdy_in is low.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r        <= IF_IDLE;
      pc_r           <= RESET_PC;
      stale_addr_r   <= RESET_PC;
      inst_r         <= 32'h0;
      inst_addr_r    <= 32'h0;
      start_decode_r <= 1'b0;
      icache_req_r   <= 1'b0;
      icache_addr_r  <= RESET_PC;
    end else if (rdy_in) begin
      state_r        <= state_s;
      pc_r           <= pc_s;
      stale_addr_r   <= stale_addr_s;
      inst_r         <= inst_s;
      inst_addr_r    <= inst_addr_s;
      start_decode_r <= start_decode_s;
      icache_req_r   <= icache_req_s;
      icache_addr_r  <= icache_addr_s;
    end
  end

  assign icache_req   = icache_req_r;
  assign icache_addr  = icache_addr_r;
  assign start_decode = start_decode_r;
  assign inst         = inst_r;
  assign inst_addr    = inst_addr_r;

endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: directed scenarios plus randomized traffic against
// a transaction-level model and a variable-latency icache responder.
module tb_inst_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_valid = 1'b0;
  logic [31:0] icache_inst = 32'h0;
  logic        start_decode;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        issue_signal = 1'b0;
  logic        jalr_stall = 1'b0;
  logic [31:0] next_pc = 32'h0;
  logic        wrong_predicted = 1'b0;
  logic [31:0] correct_pc = 32'h0;

  always #5 clk_in = ~clk_in;

  inst_fetcher #(.RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_valid(icache_valid), .icache_inst(icache_inst),
    .start_decode(start_decode), .inst(inst), .inst_addr(inst_addr),
    .issue_signal(issue_signal), .jalr_stall(jalr_stall), .next_pc(next_pc),
    .wrong_predicted(wrong_predicted), .correct_pc(correct_pc)
  );

  int tests = 0;
  int fails = 0;

  // Model: expected outputs plus architectural PC and "response must be dropped".
  logic        m_started, m_req, m_sd, m_discard;
  logic [31:0] m_pc, m_addr, m_inst, m_inst_addr;

  // Icache responder state.
  bit          ic_pend = 1'b0;
  logic [31:0] ic_addr = 32'h0;
  int          ic_cnt = 0;
  bit          rand_lat = 1'b0;

  function automatic logic [31:0] ic_data(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00500093;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic icache_drive();
    if (rst_in) begin
      ic_pend      = 1'b0;
      icache_valid = 1'b0;
    end else begin
      if (ic_pend) begin
        chk("req_held", icache_req, 1'b1);
        chk("addr_stable", icache_addr, ic_addr);
      end
      if (!rdy_in) begin
        icache_valid = 1'b0;
      end else if (ic_pend && ic_cnt == 0) begin
        icache_valid = 1'b1;
        icache_inst  = ic_data(ic_addr);
        ic_pend      = 1'b0;
      end else begin
        icache_valid = 1'b0;
        if (ic_pend) ic_cnt--;
        else if (icache_req) begin
          ic_pend = 1'b1;
          ic_addr = icache_addr;
          ic_cnt  = rand_lat ? int'($urandom_range(0, 2)) : 1;
        end
      end
    end
  endtask

  task automatic model_update();
    if (rst_in) begin
      m_started = 1'b0; m_req = 1'b0; m_sd = 1'b0; m_discard = 1'b0;
      m_pc = 32'h0; m_addr = 32'h0; m_inst = 32'h0; m_inst_addr = 32'h0;
    end else if (rdy_in) begin
      if (!m_started) begin
        m_started = 1'b1; m_req = 1'b1; m_addr = m_pc;
      end else if (m_sd) begin
        if (wrong_predicted || issue_signal) begin
          m_pc  = wrong_predicted ? correct_pc : next_pc;
          m_sd  = 1'b0; m_req = 1'b1; m_addr = m_pc;
        end
      end else if (!m_req) begin
        if (wrong_predicted) m_pc = correct_pc;
        m_req = 1'b1; m_addr = m_pc;
      end else if (icache_valid) begin
        if (m_discard) begin
          m_discard = 1'b0;
          if (wrong_predicted) m_pc = correct_pc;
          m_addr = m_pc;
        end else if (wrong_predicted) begin
          m_pc = correct_pc; m_req = 1'b0;
        end else begin
          m_inst = icache_inst; m_inst_addr = m_pc; m_sd = 1'b1; m_req = 1'b0;
        end
      end else if (wrong_predicted) begin
        m_discard = 1'b1; m_pc = correct_pc;
      end
    end
  endtask

  task automatic tick_end();
    @(posedge clk_in);
    model_update();
    #1;
    chk("icache_req", icache_req, m_req);
    chk("start_decode", start_decode, m_sd);
    chk("inst", inst, m_inst);
    chk("inst_addr", inst_addr, m_inst_addr);
    if (m_req) chk("icache_addr", icache_addr, m_addr);
    chk("sd_req_exclusive", start_decode & icache_req, 1'b0);
  endtask

  task automatic step();
    @(negedge clk_in);
    icache_drive();
    tick_end();
  endtask

  task automatic wait_sd();
    int n = 0;
    while (!start_decode && n < 20) begin
      step();
      n++;
    end
    chk("wait_sd_timeout", start_decode, 1'b1);
  endtask

  initial begin
    bit saw;
    // Reset and first fetch with a two-cycle icache.
    step(); step();
    chk("rst_req", icache_req, 1'b0);
    chk("rst_addr", icache_addr, 32'h0);
    chk("rst_sd", start_decode, 1'b0);
    chk("rst_inst", inst, 32'h0);
    rst_in = 1'b0;
    step();
    chk("t1_req", icache_req, 1'b1);
    chk("t1_addr", icache_addr, 32'h0);
    step(); step();
    chk("t1_not_yet", start_decode, 1'b0);
    step();
    chk("t1_sd", start_decode, 1'b1);
    chk("t1_inst", inst, 32'h00500093);
    chk("t1_inst_addr", inst_addr, 32'h0);

    // Issue to 0x4.
    issue_signal = 1'b1; next_pc = 32'h4;
    step();
    issue_signal = 1'b0;
    chk("t2_req", icache_req, 1'b1);
    chk("t2_addr", icache_addr, 32'h4);
    chk("t2_sd", start_decode, 1'b0);

    // JALR stall holds the instruction, then issue to 0x100.
    wait_sd();
    jalr_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_sd", start_decode, 1'b1);
      chk("t3_inst", inst, ic_data(32'h4));
      chk("t3_inst_addr", inst_addr, 32'h4);
    end
    jalr_stall = 1'b0; issue_signal = 1'b1; next_pc = 32'h100;
    step();
    issue_signal = 1'b0;
    chk("t3_addr", icache_addr, 32'h100);

    // Flush before the response: stale 0x8 is dropped, then 0x200.
    wait_sd();
    issue_signal = 1'b1; next_pc = 32'h8;
    step();
    issue_signal = 1'b0;
    chk("t4_addr8", icache_addr, 32'h8);
    wrong_predicted = 1'b1; correct_pc = 32'h200;
    step();
    wrong_predicted = 1'b0;
    chk("t4_drop_req", icache_req, 1'b1);
    chk("t4_drop_addr", icache_addr, 32'h8);
    saw = 1'b0;
    for (int i = 0; i < 10 && !saw; i++) begin
      step();
      saw = icache_valid;
      chk("t4_no_present", start_decode, 1'b0);
    end
    chk("t4_resp_seen", saw, 1'b1);
    chk("t4_req", icache_req, 1'b1);
    chk("t4_addr", icache_addr, 32'h200);
    wait_sd();
    chk("t4_inst_addr", inst_addr, 32'h200);

    // Flush colliding with the response at 0xC.
    issue_signal = 1'b1; next_pc = 32'hC;
    step();
    issue_signal = 1'b0;
    chk("t5_addrC", icache_addr, 32'hC);
    correct_pc = 32'h300;
    saw = 1'b0;
    for (int i = 0; i < 10 && !saw; i++) begin
      @(negedge clk_in);
      icache_drive();
      wrong_predicted = icache_valid;
      saw = icache_valid;
      tick_end();
    end
    wrong_predicted = 1'b0;
    chk("t5_hit", saw, 1'b1);
    chk("t5_gap_req", icache_req, 1'b0);
    chk("t5_gap_sd", start_decode, 1'b0);
    step();
    chk("t5_req", icache_req, 1'b1);
    chk("t5_addr", icache_addr, 32'h300);

    // rdy_in low during HOLD freezes everything.
    wait_sd();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue_signal = (i % 2 == 0);
      next_pc = 32'h40;
      step();
      chk("t6_sd", start_decode, 1'b1);
      chk("t6_inst_addr", inst_addr, 32'h300);
      chk("t6_req", icache_req, 1'b0);
    end
    rdy_in = 1'b1; issue_signal = 1'b1; next_pc = 32'h40;
    step();
    issue_signal = 1'b0;
    chk("t6_addr", icache_addr, 32'h40);
    chk("t6_req_on", icache_req, 1'b1);

    // Randomized traffic.
    rand_lat = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_in);
      rst_in          = ($urandom_range(0, 299) == 0);
      rdy_in          = ($urandom_range(0, 7) != 0);
      issue_signal    = ($urandom_range(0, 2) == 0);
      jalr_stall      = ($urandom_range(0, 3) == 0);
      next_pc         = $urandom_range(0, 1023) * 32'd4;
      wrong_predicted = ($urandom_range(0, 11) == 0);
      correct_pc      = $urandom();
      icache_drive();
      tick_end();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
